// File: rtl/pktchain_frame_disassemble.sv
// pktchain_frame_disassemble: 2-entry frame FIFO serialised MSB-first into phits
module pktchain_frame_disassemble #(
  parameter int DATA_WIDTH = 32,
  parameter int PHIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  frame_full,
  input  logic                  frame_wr,
  input  logic [DATA_WIDTH-1:0] frame_i,
  input  logic                  phit_o_full,
  output logic                  phit_o_wr,
  output logic [PHIT_WIDTH-1:0] phit_o,
  output logic                  idle
);
  localparam int N  = DATA_WIDTH / PHIT_WIDTH;
  localparam int IW = $clog2(N);
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] sh;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  push, pop, last;
  always_comb begin
    frame_full = cnt_q == 2'd2;
    idle       = cnt_q == 2'd0;
    push       = frame_wr & ~frame_full;
    phit_o_wr  = ~idle & ~phit_o_full;
    last       = idx_q == IW'(N - 1);
    pop        = phit_o_wr & last;
    sh         = mem_q[rd_q] << (int'(idx_q) * PHIT_WIDTH);
    phit_o     = idle ? '0 : sh[DATA_WIDTH-1 -: PHIT_WIDTH];
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    rd_d       = rd_q ^ pop;
    idx_d      = phit_o_wr ? (last ? '0 : idx_q + IW'(1)) : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rd_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      idx_q <= idx_d;
    end
  end
  // With one entry occupied the free slot is the one opposite the head
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[rd_q ^ cnt_q[0]] <= frame_i;
  end
endmodule

// File: tb/tb_pktchain_frame_disassemble.sv
// tb_pktchain_frame_disassemble: directed and random checks against a byte-queue model
module tb_pktchain_frame_disassemble;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_full;
  logic        frame_wr = 1'b0;
  logic [31:0] frame_i = '0;
  logic        phit_o_full = 1'b0;
  logic        phit_o_wr;
  logic [7:0]  phit_o;
  logic        idle;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  bq [$];

  pktchain_frame_disassemble dut (
    .clk(clk), .rst(rst), .frame_full(frame_full), .frame_wr(frame_wr),
    .frame_i(frame_i), .phit_o_full(phit_o_full), .phit_o_wr(phit_o_wr),
    .phit_o(phit_o), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pending phits as a flat byte stream; word occupancy is ceil(bytes/4)
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst) bq.delete();
    else begin
      do_pop  = bq.size() > 0 && !phit_o_full;
      do_push = frame_wr && bq.size() <= 4;
      if (do_pop) void'(bq.pop_front());
      if (do_push) for (int k = 0; k < 4; k++) bq.push_back(frame_i[31-8*k -: 8]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chkb("m_full", frame_full, bq.size() > 4);
      chkb("m_wr", phit_o_wr, bq.size() > 0 && !phit_o_full);
      chkp("m_phit", phit_o, bq.size() > 0 ? bq[0] : 8'h00);
      chkb("m_idle", idle, bq.size() == 0);
    end
  end

  task automatic tick(input logic fw, input logic [31:0] d, input logic pf, input logic r);
    @(posedge clk);
    #1;
    frame_wr = fw;
    frame_i = d;
    phit_o_full = pf;
    rst = r;
    @(negedge clk);
  endtask

  task automatic ph(input string nm, input logic [7:0] e);
    chkb({nm, "_wr"}, phit_o_wr, 1'b1);
    chkp(nm, phit_o, e);
  endtask

  task automatic stream(input string nm, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      ph(nm, w[31-8*k -: 8]);
    end
  endtask

  initial begin
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chkb("rst_full", frame_full, 1'b0);
    chkb("rst_wr", phit_o_wr, 1'b0);
    chkp("rst_phit", phit_o, 8'h00);
    chkb("rst_idle", idle, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    // single frame, 1-cycle latency
    tick(1'b1, 32'hA1B2C3D4, 1'b0, 1'b0);
    chkb("t1_pre_idle", idle, 1'b1);
    stream("t1", 32'hA1B2C3D4);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chkb("t1_idle", idle, 1'b1);
    chkb("t1_wr_end", phit_o_wr, 1'b0);
    // back-to-back frames
    tick(1'b1, 32'h11223344, 1'b0, 1'b0);
    tick(1'b1, 32'h55667788, 1'b0, 1'b0);
    ph("t2", 8'h11);
    chkb("t2_full0", frame_full, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t2", 8'h22);
    chkb("t2_full1", frame_full, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t2", 8'h33);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t2", 8'h44);
    stream("t2b", 32'h55667788);
    chkb("t2_full_end", frame_full, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chkb("t2_idle", idle, 1'b1);
    // backpressure holds C3
    tick(1'b1, 32'hA1B2C3D4, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t3", 8'hA1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t3", 8'hB2);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      chkb("t3_hold_wr", phit_o_wr, 1'b0);
      chkp("t3_hold", phit_o, 8'hC3);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t3", 8'hC3);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t3", 8'hD4);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chkb("t3_idle", idle, 1'b1);
    // write while full is dropped
    tick(1'b1, 32'h10203040, 1'b0, 1'b0);
    tick(1'b1, 32'h50607080, 1'b0, 1'b0);
    ph("t4", 8'h10);
    tick(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    chkb("t4_full", frame_full, 1'b1);
    chkp("t4_hold", phit_o, 8'h20);
    for (int k = 1; k < 8; k++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      ph("t4", 8'((k < 4 ? 8'h10 : 8'h50) + 8'((k % 4) * 16)));
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chkb("t4_idle", idle, 1'b1);
    // reset mid-word, with a write in the reset cycle
    tick(1'b1, 32'hA1B2C3D4, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t5", 8'hA1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    ph("t5", 8'hB2);
    tick(1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chkb("t5_wr", phit_o_wr, 1'b0);
    chkb("t5_idle", idle, 1'b1);
    chkp("t5_phit", phit_o, 8'h00);
    tick(1'b1, 32'h01020304, 1'b0, 1'b0);
    stream("t5b", 32'h01020304);
    // random traffic
    for (int i = 0; i < 10000; i++)
      tick(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 499) == 0);
    for (int i = 0; i < 12; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    chkb("drain_idle", idle, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
